// File: rtl/lsu_dtim_initiator.sv
// lsu_dtim_initiator: RV32I load/store initiator for the DTIM data memory, one access at a time
module lsu_dtim_initiator #(
  parameter logic [31:0] DTIM_BASE = 32'h8000_0000,
  parameter int DTIM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dtim_valid,
  output logic [31:0] dtim_addr,
  output logic [3:0]  dtim_wmask,
  output logic [31:0] dtim_wdata,
  input  logic [31:0] dtim_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [31:0] WIN_MASK = (32'd1 << DTIM_AW) - 32'd1;
  state_t state, nxt;
  logic        st_q, err_q, f3_ok, mis, oow, err, acc;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [3:0]  mask, mask_q;
  logic [31:0] addr_q, wdata_q, rdata_q, sh, ext;
  always_comb begin
    f3_ok = req_store ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                      : (req_funct3[1:0] != 2'b11 && req_funct3 != 3'b110);
    mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    oow = (req_addr & ~WIN_MASK) != DTIM_BASE;
    err = !f3_ok || mis || oow;
    acc = state == IDLE && req_valid;
    mask = !req_store ? 4'b0000 :
           req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
           req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    sh = dtim_rdata >> {lo_q, 3'b000};
    ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
          f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (err ? DONE : ISSUE) : IDLE;
      ISSUE:   nxt = st_q ? DONE : WAIT;
      WAIT:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      lo_q    <= 2'd0;
      mask_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else if (acc) begin
      st_q    <= req_store;
      err_q   <= err;
      f3_q    <= req_funct3;
      lo_q    <= req_addr[1:0];
      mask_q  <= err ? 4'd0 : mask;
      addr_q  <= {req_addr[31:2], 2'b00};
      wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
      rdata_q <= 32'd0;
    end else if (state == WAIT) begin
      rdata_q <= ext;
    end
  end
  assign req_ready  = state == IDLE;
  assign resp_valid = state == DONE;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dtim_valid = state == ISSUE;
  assign dtim_addr  = addr_q;
  assign dtim_wmask = mask_q;
  assign dtim_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_dtim_initiator.sv
// tb_lsu_dtim_initiator: directed checks of the DTIM load/store initiator against hand-computed values
module tb_lsu_dtim_initiator;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, dtim_valid;
  logic [31:0] resp_rdata, dtim_addr, dtim_wdata, dtim_rdata;
  logic [3:0]  dtim_wmask;
  logic        ovr = 1'b0;
  logic [31:0] ovr_val = 32'd0, mem_rd = 32'd0;
  logic [31:0] mem [0:1023];
  int checks = 0, errors = 0;

  lsu_dtim_initiator dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dtim_valid(dtim_valid), .dtim_addr(dtim_addr),
    .dtim_wmask(dtim_wmask), .dtim_wdata(dtim_wdata), .dtim_rdata(dtim_rdata)
  );

  always #5 clk = ~clk;

  // memory model: read word appears the cycle after the access
  always @(posedge clk)
    if (dtim_valid) begin
      for (int b = 0; b < 4; b++)
        if (dtim_wmask[b]) mem[dtim_addr[11:2]][8*b +: 8] <= dtim_wdata[8*b +: 8];
      mem_rd <= mem[dtim_addr[11:2]];
    end
  assign dtim_rdata = ovr ? ovr_val : mem_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
    req(st, f3, a, 32'hFFFF_FFFF);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " resp_err"}, 32'(resp_err), 32'd1);
    chk({tag, " rdata"}, resp_rdata, 32'd0);
    chk({tag, " no dtim"}, 32'(dtim_valid), 32'd0);
    tick();
    chk({tag, " idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
    chk({tag, " still no dtim"}, 32'(dtim_valid), 32'd0);
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp_addr, input logic [31:0] exp);
    req(1'b0, f3, a, 32'd0);
    chk({tag, " dtim_valid"}, 32'(dtim_valid), 32'd1);
    chk({tag, " dtim_addr"}, dtim_addr, exp_addr);
    chk({tag, " wmask"}, 32'(dtim_wmask), 32'd0);
    tick();
    ovr = 1'b1; ovr_val = word;
    chk({tag, " wait"}, {29'd0, dtim_valid, resp_valid, req_ready}, 32'd0);
    tick();
    ovr = 1'b0;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " rdata"}, resp_rdata, exp);
    tick();
    chk({tag, " back idle"}, {30'd0, req_ready, resp_valid}, 32'd2);
  endtask

  initial begin
    tick(); tick();
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst resp", {29'd0, resp_valid, resp_err, dtim_valid}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst addr", dtim_addr, 32'd0);
    chk("rst wdata", dtim_wdata, 32'd0);
    chk("rst wmask", 32'(dtim_wmask), 32'd0);
    rst = 1'b0;
    tick();

    // SB at the top byte lane
    req(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5);
    chk("sb dtim_valid", 32'(dtim_valid), 32'd1);
    chk("sb ready low", 32'(req_ready), 32'd0);
    chk("sb dtim_addr", dtim_addr, 32'h8000_0000);
    chk("sb wmask", 32'(dtim_wmask), 32'h8);
    chk("sb wdata", dtim_wdata, 32'hA500_0000);
    tick();
    chk("sb resp_valid", 32'(resp_valid), 32'd1);
    chk("sb resp_err", 32'(resp_err), 32'd0);
    chk("sb rdata", resp_rdata, 32'd0);
    chk("sb dtim off", 32'(dtim_valid), 32'd0);
    tick();
    chk("sb idle", {30'd0, req_ready, resp_valid}, 32'd2);

    // SH to the upper half
    req(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD);
    chk("sh wmask", 32'(dtim_wmask), 32'hC);
    chk("sh wdata", dtim_wdata, 32'hABCD_0000);
    tick(); tick();

    load_case("lb",  3'b000, 32'h8000_0003, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80);
    load_case("lbu", 3'b100, 32'h8000_0003, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0080);
    load_case("lh",  3'b001, 32'h8000_0106, 32'h7ABC_0000, 32'h8000_0104, 32'h0000_7ABC);
    load_case("lh neg", 3'b001, 32'h8000_0000, 32'h0000_8001, 32'h8000_0000, 32'hFFFF_8001);
    load_case("lhu", 3'b101, 32'h8000_0002, 32'hF00D_0000, 32'h8000_0000, 32'h0000_F00D);
    load_case("lw top", 3'b010, 32'h8000_0FFC, 32'hCAFE_F00D, 32'h8000_0FFC, 32'hCAFE_F00D);

    err_case("lw misaligned", 1'b0, 3'b010, 32'h8000_0002);
    err_case("lh misaligned", 1'b0, 3'b001, 32'h8000_0001);
    err_case("sw out of window", 1'b1, 3'b010, 32'h0000_1000);
    err_case("lw past window", 1'b0, 3'b010, 32'h8000_1000);
    err_case("load f3 110", 1'b0, 3'b110, 32'h8000_0000);
    err_case("store f3 100", 1'b1, 3'b100, 32'h8000_0000);

    // back-to-back SW then LW, request held through DONE must be ignored until IDLE
    req(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF);
    chk("b2b sw wmask", 32'(dtim_wmask), 32'hF);
    tick();
    chk("b2b sw done", 32'(resp_valid), 32'd1);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0010;
    tick();
    chk("b2b ignored in done", {30'd0, req_ready, dtim_valid}, 32'd2);
    tick();
    req_valid = 1'b0;
    chk("b2b lw issue", 32'(dtim_valid), 32'd1);
    tick(); tick();
    chk("b2b lw resp", 32'(resp_valid), 32'd1);
    chk("b2b lw rdata", resp_rdata, 32'hDEAD_BEEF);
    tick();

    // reset while waiting for load data
    req(1'b0, 3'b010, 32'h8000_0010, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid ready", 32'(req_ready), 32'd1);
    chk("rst mid quiet", {30'd0, resp_valid, dtim_valid}, 32'd0);
    tick();
    chk("rst mid quiet+1", {30'd0, resp_valid, dtim_valid}, 32'd0);
    tick();
    chk("rst mid quiet+2", {29'd0, resp_valid, dtim_valid, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_dtim_initiator.md
Name: lsu_dtim_initiator

Overview:
- Load/store unit: the initiator side of the DTIM data-memory interface for the RV32I core.
- Accepts one load or store request from the execute stage, range- and alignment-checks it, and issues a single DTIM access.
- Generates the byte write mask and lane-shifted write data for stores; extracts and sign/zero-extends load data from the returned word.
- Returns a one-cycle response pulse to the core; the core stalls on req_ready/resp_valid.

Parameters:
- DTIM_BASE, 32'h8000_0000, byte base address of the DTIM window.
- DTIM_AW, 12, log2 of the DTIM window size in bytes; word index = addr[DTIM_AW-1:2].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-window, or illegal funct3
- dtim_valid  out  1  DTIM access strobe
- dtim_addr  out  32  word-aligned byte address (addr[1:0] forced to 0)
- dtim_wmask  out  4  byte write enables; 4'b0000 for loads
- dtim_wdata  out  32  lane-shifted store data
- dtim_rdata  in  32  DTIM read word, valid the cycle after the access

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dtim_valid=0, dtim_wmask=0, dtim_addr=0, dtim_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_store, req_funct3, req_addr and req_wdata; compute err.
  - err=1 -> go to DONE with resp_err=1; no DTIM access is made.
  - Otherwise -> go to ISSUE.
- err conditions:
  - funct3 illegal. Loads accept only 000, 001, 010, 100, 101; stores accept only 000, 001, 010.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - (addr & ~(2^DTIM_AW-1)) != DTIM_BASE.
- ISSUE:
  - dtim_valid=1 for exactly this cycle; all dtim_* outputs are driven from registers.
  - Store masks: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - Store data: dtim_wdata = req_wdata << (8*addr[1:0]); upper bits are truncated.
  - Stores -> DONE. Loads -> WAIT.
- WAIT:
  - Shift dtim_rdata right by 8*addr[1:0].
  - Extend bits [7:0] for byte loads and [15:0] for half loads: sign-extend when funct3[2]=0, zero-extend when funct3[2]=1. Word loads pass through.
  - Register the result into resp_rdata, then -> DONE.
- DONE: resp_valid=1 for exactly one cycle, then -> IDLE. resp_rdata and resp_err are held valid only during this cycle.
- Latency, request accepted at cycle T:
  - Store: dtim_valid at T+1, resp_valid at T+2.
  - Load: dtim_valid at T+1, capture at T+2, resp_valid at T+3.
  - Error: resp_valid at T+1.
- Throughput: at most one outstanding request. req_valid outside IDLE is ignored (req_ready=0). A new request can be accepted in the cycle after DONE.
- dtim_valid is never asserted in IDLE, WAIT or DONE.
- Reset mid-operation: all state returns to IDLE the next edge. No response is issued for the aborted request; an in-flight store in ISSUE may still complete at that edge.

Test Plan:
- SB: addr 0x8000_0003, wdata 0x0000_00A5 -> cycle T+1 dtim_valid=1, dtim_addr=0x8000_0000, dtim_wmask=4'b1000, dtim_wdata=0xA500_0000; resp_valid at T+2, resp_err=0.
- LB / LBU: addr 0x8000_0003, dtim_rdata=0x80FF_1234 at T+2. LB -> resp_rdata=0xFFFF_FF80 at T+3; LBU on the same data -> 0x0000_0080.
- LH: addr 0x8000_0106, rdata 0x7ABC_0000 -> dtim_addr=0x8000_0104, dtim_wmask=0, resp_rdata=0x0000_7ABC.
- Misaligned / out-of-window:
  - LW addr 0x8000_0002 -> resp_valid at T+1, resp_err=1, resp_rdata=0, dtim_valid never asserted.
  - SW addr 0x0000_1000 -> same error response.
  - Illegal funct3 110 -> same error response.
- Back-to-back: SW 0x8000_0010=0xDEAD_BEEF, then LW same address with the model DTIM returning the written word -> the load is accepted the cycle after the store's DONE, and resp_rdata=0xDEAD_BEEF.
- Reset: assert rst during WAIT of an LW -> next cycle IDLE, req_ready=1, resp_valid stays 0, and no spurious dtim_valid follows.
